seq_slice_adder: RTL

SEQ_SLICE_ADDER -- requirements
Module: seq_slice_adder

---
 rtl/alu_pkg.sv | 14 +
 rtl/adder_slice.sv | 29 ++
 rtl/seq_slice_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential slice adder: FSM encodings and the
// WIDTH/SLICE legality check.
package alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // WIDTH must be a positive whole number of slices.
    function automatic bit slice_cfg_legal(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// SLICE-bit combinational ripple adder; also exposes the carry into the
// slice MSB so the parent can derive signed overflow.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum_o = '0;
        c[0] = cin_i;
        for (int i = 0; i < SLICE; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[SLICE];
    assign cmsb_o = c[SLICE-1];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per RUN cycle, carry held
// in a register between cycles; results only update on the done cycle.
module seq_slice_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam bit LEGAL = slice_cfg_legal(WIDTH, SLICE);

    if (!LEGAL) begin : g_bad_cfg
        $error("seq_slice_adder: WIDTH must be a positive multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] f_q;
    logic             cout_q, ovf_q;

    logic [SLICE-1:0] s_sum;
    logic             s_cout, s_cmsb;
    logic             accept, last;

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last   = (idx_q == CNT_W'(NSL - 1));

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a_i    (a_q[idx_q*SLICE +: SLICE]),
        .b_i    (b_q[idx_q*SLICE +: SLICE]),
        .cin_i  (carry_q),
        .sum_o  (s_sum),
        .cout_o (s_cout),
        .cmsb_o (s_cmsb)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The final slice is merged combinationally so F loads the full word at once.
    always_comb begin
        part_d = part_q;
        part_d[idx_q*SLICE +: SLICE] = s_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q   <= '0;
                carry_q <= sub | C0;
            end else if (state_q == ST_RUN) begin
                idx_q   <= idx_q + 1'b1;
                carry_q <= s_cout;
                if (last) begin
                    f_q    <= part_d;
                    cout_q <= s_cout;
                    ovf_q  <= s_cout ^ s_cmsb;
                end
            end
        end
    end

    // Operand and partial-sum storage needs no reset: every bit is rewritten
    // before it can reach an output.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= A;
            b_q <= sub ? ~B : B;
        end
        if (state_q == ST_RUN) begin
            part_q <= part_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign F    = f_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule
